// File: rtl/lcfg_arb_pkg.sv
// Shared definitions for the lcfg configuration-bus arbiters: bus widths,
// FSM encoding and the default abort read data.
package lcfg_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Requester index width: clog2(n), never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcfg_cfg_arbiter_if.sv
// Outgoing irdy/trdy configuration bus. The master holds irdy and the payload
// stable until it samples trdy high; trdy is a single-cycle completion that
// also qualifies rd_data.
interface lcfg_cfg_arbiter_if;
    import lcfg_arb_pkg::*;

    logic              cfgo_irdy;
    logic              cfgo_trdy;
    logic [ADDR_W-1:0] cfgo_addr;
    logic              cfgo_write;
    logic [DATA_W-1:0] cfgo_wr_data;
    logic [DATA_W-1:0] cfgo_rd_data;

    modport master (
        output cfgo_irdy, cfgo_addr, cfgo_write, cfgo_wr_data,
        input  cfgo_trdy, cfgo_rd_data
    );

    modport slave (
        input  cfgo_irdy, cfgo_addr, cfgo_write, cfgo_wr_data,
        output cfgo_trdy, cfgo_rd_data
    );

endinterface

// File: rtl/lcfg_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// the slot after last_grant, wrapping at N_REQ.
module lcfg_rr_pick #(
    parameter int N_REQ   = 2,
    parameter int REQ_IDW = 1
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [REQ_IDW-1:0] last_grant,
    output logic               any_req,
    output logic [REQ_IDW-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        any_req = |req;
        grant   = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(last_grant) + off) % N_REQ;
            if (!found && req[idx]) begin
                grant = REQ_IDW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcfg_cfg_arbiter.sv
// Round-robin arbiter sharing one irdy/trdy config bus between N_REQ
// requesters, with registered payload and a target-timeout watchdog.
module lcfg_cfg_arbiter
    import lcfg_arb_pkg::*;
#(
    parameter int                N_REQ    = 2,
    parameter int                REQ_IDW  = idx_width(N_REQ),
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_irdy,
    input  logic [ADDR_W*N_REQ-1:0]  req_addr,
    input  logic [N_REQ-1:0]         req_write,
    input  logic [DATA_W*N_REQ-1:0]  req_wr_data,
    output logic [N_REQ-1:0]         req_trdy,
    output logic [DATA_W-1:0]        req_rd_data,
    lcfg_cfg_arbiter_if.master       cfgo,
    output logic                     err_timeout,
    output logic [REQ_IDW-1:0]       err_req_id,
    output state_e                   dbg_state
);

    // The counter only has to reach TIMEOUT-1; it then saturates.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e              state_q, state_d;
    logic [REQ_IDW-1:0]  grant_q, grant_d;
    logic [REQ_IDW-1:0]  last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [REQ_IDW-1:0]  err_id_q, err_id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                pick_any;
    logic [REQ_IDW-1:0]  pick_idx;

    lcfg_rr_pick #(
        .N_REQ   (N_REQ),
        .REQ_IDW (REQ_IDW)
    ) u_pick (
        .req        (req_irdy),
        .last_grant (last_q),
        .any_req    (pick_any),
        .grant      (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        err_id_d = err_id_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    addr_d  = req_addr[ADDR_W*int'(pick_idx) +: ADDR_W];
                    write_d = req_write[pick_idx];
                    wdata_d = req_wr_data[DATA_W*int'(pick_idx) +: DATA_W];
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A completion in the final watchdog cycle still wins.
                if (cfgo.cfgo_trdy) begin
                    rdata_d = cfgo.cfgo_rd_data;
                    state_d = ST_DONE;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    rdata_d  = ERR_DATA;
                    err_d    = 1'b1;
                    err_id_d = grant_q;
                    state_d  = ST_DONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            last_q   <= REQ_IDW'(N_REQ - 1);
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            err_id_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            err_id_q <= err_id_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        req_trdy = '0;
        if (state_q == ST_DONE) req_trdy[grant_q] = 1'b1;
    end

    assign cfgo.cfgo_irdy    = (state_q == ST_BUSY);
    assign cfgo.cfgo_addr    = addr_q;
    assign cfgo.cfgo_write   = write_q;
    assign cfgo.cfgo_wr_data = wdata_q;
    assign req_rd_data       = rdata_q;
    assign err_timeout       = err_q;
    assign err_req_id        = err_id_q;
    assign dbg_state         = state_q;

endmodule

// File: doc/lcfg_cfg_arbiter.md
Name: lcfg_cfg_arbiter

Overview:
Shares one outgoing irdy/trdy configuration bus (16-bit address, 32-bit data) between N requesters, such as several TV80 config-bus drivers or a boot loader. It uses round-robin arbitration and holds each grant until the target completes. It registers the winning request onto the bus and returns read data to the winner. A timeout watchdog terminates transactions that the target never acknowledges.

Parameters:
N_REQ, 2, number of requesters (2..8)
REQ_IDW, 1, width of the requester index, equal to clog2(N_REQ) with a minimum of 1
TIMEOUT, 255, cycles in BUSY without cfgo_trdy before abort; 0 disables the watchdog
ERR_DATA, 32'hDEAD_BEEF, read data returned to the requester on timeout

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
req_irdy  in  N_REQ  per-requester request valid; held with its payload until the requester samples req_trdy high
req_addr  in  16*N_REQ  packed addresses; requester i uses bits [16i+15:16i]
req_write  in  N_REQ  1 = write, 0 = read
req_wr_data  in  32*N_REQ  packed write data
req_trdy  out  N_REQ  one-cycle completion pulse to the granted requester
req_rd_data  out  32  read data broadcast to all requesters; valid only with req_trdy
cfgo_irdy  out  1  outgoing bus request
cfgo_trdy  in  1  target completion
cfgo_addr  out  16  registered address
cfgo_write  out  1  registered direction
cfgo_wr_data  out  32  registered write data
cfgo_rd_data  in  32  target read data, valid with cfgo_trdy
err_timeout  out  1  one-cycle pulse when a transaction is aborted
err_req_id  out  REQ_IDW  index of the aborted requester, held until the next abort

Behaviour:
- States: IDLE, BUSY, DONE. Encoding lives in the shared package.
- Reset values:
  - state = IDLE
  - last_grant = N_REQ-1, so requester 0 wins first
  - cfgo_irdy, cfgo_write, req_trdy, err_timeout = 0
  - cfgo_addr, cfgo_wr_data, req_rd_data = 0
  - err_req_id = 0
  - timeout counter = 0
- IDLE, when any req_irdy is set:
  - Pick the first set bit scanning upward from (last_grant+1) mod N_REQ, with wrap-around.
  - Register grant and last_grant.
  - Register addr, write and wr_data from the winner onto the cfgo_* outputs.
  - Next state is BUSY. When no req_irdy is set, stay in IDLE.
- BUSY:
  - cfgo_irdy = 1. The cfgo payload is stable for the whole state and is not re-sampled from the requester.
  - On cfgo_trdy: capture cfgo_rd_data into req_rd_data (writes capture it too), go to DONE.
  - Otherwise, if TIMEOUT != 0 and the counter equals TIMEOUT-1: load ERR_DATA into req_rd_data, pulse err_timeout, latch err_req_id = grant, go to DONE.
  - cfgo_trdy and timeout in the same cycle: trdy wins and no error is flagged.
- DONE:
  - req_trdy[grant] = 1 for exactly one cycle; cfgo_irdy = 0.
  - Next state is always IDLE. Requesters must drop or replace irdy on the edge where they sample req_trdy, so IDLE never re-grants a completed request.
- Latency: req_irdy seen in IDLE at cycle t gives cfgo_irdy high at t+1. cfgo_trdy at cycle m gives req_trdy at m+1. Minimum transaction is 3 cycles.
- cfgo_irdy is a decoded state bit with no combinational path from any input.
- Timeout counter: clears on entry to BUSY and increments each BUSY cycle. It saturates and never wraps.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N_REQ-1,0. Each requester waits at most N_REQ-1 transactions.
- A requester dropping req_irdy while granted is a protocol violation and does not abort the bus cycle.
- Reset asserted mid-transaction: all state returns to reset values on the next edge. cfgo_irdy drops without waiting for trdy, and no req_trdy is issued.

Decomposition:
- Package lcfg_arb_pkg: state encoding (IDLE/BUSY/DONE), default ERR_DATA, and address/data width constants (16/32).
- Sub-module lcfg_rr_pick: purely combinational round-robin picker.
  - Inputs: request vector, last_grant.
  - Outputs: any_req, grant index.
  - Parameterised by N_REQ. It is reusable by other lcfg arbiters.

Test Plan:
- Single read: req0 reads addr 16'h0104, target answers after 3 cycles with 32'h1234_5678 -> cfgo_irdy high for 4 cycles; req_trdy = 2'b01 for one cycle with req_rd_data = 32'h1234_5678.
- Contention: req0 and req1 request in the same cycle straight after reset -> req0 served first, then req1. With both then held continuously, grants alternate 1,0,1,0 with no back-to-back repeat.
- Write payload stability: req1 writes 32'hCAFE_F00D to 16'h0200 and changes its req_wr_data while BUSY -> cfgo_wr_data stays 32'hCAFE_F00D until trdy.
- Timeout: TIMEOUT = 8, target never responds -> after 8 BUSY cycles, err_timeout pulses once, err_req_id = requester index, req_rd_data = 32'hDEAD_BEEF, arbiter returns to IDLE. A trdy arriving in the 8th cycle gives normal completion with no error.
- Reset mid-transaction: assert reset during BUSY -> next cycle cfgo_irdy = 0, no req_trdy, and the next request goes to requester 0.
- Wrap-around: N_REQ = 3, last grant = 2, requests from 0 and 2 -> requester 0 granted.
